// File: rtl/alu_pkg.sv
// Purpose: shared opcodes, FSM state encoding and default width for the
//          two-requester ALU arbiter and its combinational core.
// Contents: WIDTH_DEF, OP_* opcodes, state_t, is_shift_op().
package alu_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  localparam logic [2:0] OP_NOT = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Shifts are the only ops handled by the bit-serial sequencer.
  function automatic logic is_shift_op(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purpose: combinational ALU for the single-cycle ops (NOT/AND/OR/XOR/ADD/SUB).
// Ports:
//   i_op     opcode
//   i_a/i_b  operands
//   o_result result (A passes through for shift opcodes, unused by the top)
//   o_carry  carry out of ADD, borrow of SUB (A<B unsigned), else 0
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry
);

  logic [WIDTH:0] w_wide;

  // ADD/SUB are evaluated one bit wider so the top bit is carry/borrow.
  always_comb begin
    w_wide   = '0;
    o_result = '0;
    o_carry  = 1'b0;
    case (i_op)
      OP_NOT: o_result = ~i_a;
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_ADD: begin
        w_wide   = {1'b0, i_a} + {1'b0, i_b};
        o_result = w_wide[WIDTH-1:0];
        o_carry  = w_wide[WIDTH];
      end
      OP_SUB: begin
        w_wide   = {1'b0, i_a} - {1'b0, i_b};
        o_result = w_wide[WIDTH-1:0];
        o_carry  = w_wide[WIDTH];
      end
      default: o_result = i_a;
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Purpose: shares one ALU between two requesters with round-robin grant.
//          Single-cycle ops go through alu_core; shifts are sequenced one bit
//          per cycle. The result is registered and held until accepted.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in{0,1}_valid/ready        request handshake (ready is combinational)
//   in{0,1}_op/_a/_b           request payload
//   out_valid/out_ready        result handshake
//   out_data/out_id            result and issuing requester
//   out_zero/out_carry         result flags
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [2:0]       in0_op,
  input  logic [WIDTH-1:0] in0_a,
  input  logic [WIDTH-1:0] in0_b,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [2:0]       in1_op,
  input  logic [WIDTH-1:0] in1_a,
  input  logic [WIDTH-1:0] in1_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  output logic             out_zero,
  output logic             out_carry
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_last_grant;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_id;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_count;

  logic             w_any_valid;
  logic             w_grant_id;
  logic [2:0]       w_in_op;
  logic [WIDTH-1:0] w_in_a;
  logic [WIDTH-1:0] w_in_b;
  logic             w_accept;
  logic             w_load_exec;
  logic             w_load_shift;
  logic             w_shift_step;
  logic             w_release;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_carry;

  // Round-robin: on a tie the requester that did not win last time is granted.
  assign w_any_valid = in0_valid | in1_valid;
  assign w_grant_id  = (in0_valid & in1_valid) ? ~r_last_grant : in1_valid;
  assign w_in_op     = w_grant_id ? in1_op : in0_op;
  assign w_in_a      = w_grant_id ? in1_a  : in0_a;
  assign w_in_b      = w_grant_id ? in1_b  : in0_b;

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_alu_res),
    .o_carry  (w_alu_carry)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_valid) w_next_state = is_shift_op(w_in_op) ? ST_SHIFT : ST_EXEC;
      ST_EXEC:  w_next_state = ST_HOLD;
      ST_SHIFT: if (r_count == '0) w_next_state = ST_HOLD;
      ST_HOLD:  if (out_ready) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Output / control strobes decoded from the current state.
  always_comb begin
    in0_ready    = 1'b0;
    in1_ready    = 1'b0;
    w_accept     = 1'b0;
    w_load_exec  = 1'b0;
    w_load_shift = 1'b0;
    w_shift_step = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept  = w_any_valid;
        in0_ready = w_any_valid & ~w_grant_id;
        in1_ready = w_any_valid & w_grant_id;
      end
      ST_EXEC: w_load_exec = 1'b1;
      ST_SHIFT: begin
        if (r_count == '0) w_load_shift = 1'b1;
        else               w_shift_step = 1'b1;
      end
      ST_HOLD: w_release = out_ready;
      default: ;
    endcase
  end

  // Request capture and bit-serial shift datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_work       <= '0;
      r_count      <= '0;
    end else if (w_accept) begin
      r_op         <= w_in_op;
      r_a          <= w_in_a;
      r_b          <= w_in_b;
      r_id         <= w_grant_id;
      r_last_grant <= w_grant_id;
      r_work       <= w_in_a;
      r_count      <= w_in_b[SHW-1:0];
    end else if (w_shift_step) begin
      // op[0] selects direction: 0 = left, 1 = logical right.
      r_work  <= r_op[0] ? (r_work >> 1) : (r_work << 1);
      r_count <= r_count - SHW'(1);
    end
  end

  // Result register; held until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= 1'b0;
      out_zero  <= 1'b0;
      out_carry <= 1'b0;
    end else if (w_load_exec) begin
      out_valid <= 1'b1;
      out_data  <= w_alu_res;
      out_id    <= r_id;
      out_zero  <= (w_alu_res == '0);
      out_carry <= w_alu_carry;
    end else if (w_load_shift) begin
      out_valid <= 1'b1;
      out_data  <= r_work;
      out_id    <= r_id;
      out_zero  <= (r_work == '0);
      out_carry <= 1'b0;
    end else if (w_release) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Purpose: self-checking bench for alu_req_arbiter: directed vector table
//          plus hand-written sequences for tie-break, hold and mid-op reset.
module tb_alu_req_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in0_valid, in0_ready, in1_valid, in1_ready;
  logic [2:0]  in0_op, in1_op;
  logic [31:0] in0_a, in0_b, in1_a, in1_b;
  logic        out_valid, out_ready, out_id, out_zero, out_carry;
  logic [31:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_zero;
    logic        exp_carry;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];

  alu_req_arbiter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_op    (in0_op),
    .in0_a     (in0_a),
    .in0_b     (in0_b),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_op    (in1_op),
    .in1_a     (in1_a),
    .in1_b     (in1_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_zero  (out_zero),
    .out_carry (out_carry)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return just after the accepting edge.
  task automatic send(input logic id, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    int n;
    if (id) begin
      in1_op = op; in1_a = a; in1_b = b; in1_valid = 1'b1;
    end else begin
      in0_op = op; in0_a = a; in0_b = b; in0_valid = 1'b1;
    end
    #1;
    n = 0;
    while (((id ? in1_ready : in0_ready) !== 1'b1) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: requester %0d got no ready expected ready within 40 cycles", id);
    end
    tick();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    // Scramble the now-ignored inputs; captured operands must not follow.
    in0_op = 3'($urandom); in0_a = $urandom; in0_b = $urandom;
    in1_op = 3'($urandom); in1_a = $urandom; in1_b = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("valid_cleared", 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int lat;
    logic saw_valid;

    vecs[0]  = '{1'b0, 3'b100, 32'hFFFF_FFFF, 32'h1,        32'h0,        1'b1, 1'b1, 1};
    vecs[1]  = '{1'b1, 3'b101, 32'h3,         32'h5,        32'hFFFF_FFFE, 1'b0, 1'b1, 1};
    vecs[2]  = '{1'b0, 3'b101, 32'h5,         32'h3,        32'h2,        1'b0, 1'b0, 1};
    vecs[3]  = '{1'b1, 3'b100, 32'h2,         32'h3,        32'h5,        1'b0, 1'b0, 1};
    vecs[4]  = '{1'b0, 3'b010, 32'hF0F0_0000, 32'h0000_F0F0, 32'hF0F0_F0F0, 1'b0, 1'b0, 1};
    vecs[5]  = '{1'b1, 3'b011, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0,       1'b1, 1'b0, 1};
    vecs[6]  = '{1'b0, 3'b001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1};
    vecs[7]  = '{1'b0, 3'b110, 32'h1,         32'h4,        32'h10,       1'b0, 1'b0, 5};
    vecs[8]  = '{1'b1, 3'b111, 32'h8000_0000, 32'd31,       32'h1,        1'b0, 1'b0, 32};
    vecs[9]  = '{1'b0, 3'b110, 32'h1234_5678, 32'h0,        32'h1234_5678, 1'b0, 1'b0, 1};
    vecs[10] = '{1'b1, 3'b110, 32'h1,         32'h25,       32'h20,       1'b0, 1'b0, 6};
    vecs[11] = '{1'b0, 3'b110, 32'h8000_0001, 32'h1,        32'h2,        1'b0, 1'b0, 2};
    vecs[12] = '{1'b1, 3'b000, 32'hFFFF_FFFF, 32'h0,        32'h0,        1'b1, 1'b0, 1};

    rst_n = 1'b0; out_ready = 1'b0;
    in0_valid = 1'b0; in0_op = '0; in0_a = '0; in0_b = '0;
    in1_valid = 1'b0; in1_op = '0; in1_a = '0; in1_b = '0;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  out_data,       32'd0);
    chk("rst_id",    32'(out_id),    32'd0);
    chk("rst_zero",  32'(out_zero),  32'd0);
    chk("rst_carry", 32'(out_carry), 32'd0);
    rst_n = 1'b1;
    tick();

    // NOT 0 with two-edge latency.
    send(1'b0, 3'b000, 32'h0, 32'h0);
    chk("not_early_valid", 32'(out_valid), 32'd0);
    wait_valid(lat);
    chk("not_lat",   32'(lat),       32'd1);
    chk("not_data",  out_data,       32'hFFFF_FFFF);
    chk("not_id",    32'(out_id),    32'd0);
    chk("not_zero",  32'(out_zero),  32'd0);
    chk("not_carry", 32'(out_carry), 32'd0);
    take();

    // Tie-break from reset: in0 first, then in1, then in0 again.
    do_reset();
    in0_op = 3'b100; in0_a = 32'h2;      in0_b = 32'h3;      in0_valid = 1'b1;
    in1_op = 3'b001; in1_a = 32'hF0F0;   in1_b = 32'hFF00;   in1_valid = 1'b1;
    #1;
    chk("tie1_rdy", 32'({in0_ready, in1_ready}), 32'b10);
    tick();
    in0_valid = 1'b0;
    wait_valid(lat);
    chk("tie1_data", out_data, 32'h5);
    chk("tie1_id", 32'(out_id), 32'd0);
    chk("tie1_hold_rdy", 32'({in0_ready, in1_ready}), 32'b00);
    take();
    chk("tie2_rdy", 32'({in0_ready, in1_ready}), 32'b01);
    tick();
    in1_valid = 1'b0;
    wait_valid(lat);
    chk("tie2_data", out_data, 32'h0000_F000);
    chk("tie2_id", 32'(out_id), 32'd1);
    take();
    in0_op = 3'b100; in0_a = 32'h2;      in0_b = 32'h3;      in0_valid = 1'b1;
    in1_op = 3'b001; in1_a = 32'hF0F0;   in1_b = 32'hFF00;   in1_valid = 1'b1;
    #1;
    chk("tie3_rdy", 32'({in0_ready, in1_ready}), 32'b10);
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    wait_valid(lat);
    chk("tie3_data", out_data, 32'h5);
    chk("tie3_id", 32'(out_id), 32'd0);
    take();

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      send(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(lat);
      chk($sformatf("vec%0d_lat", i),   32'(lat),       32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_data", i),  out_data,       vecs[i].exp_data);
      chk($sformatf("vec%0d_id", i),    32'(out_id),    32'(vecs[i].id));
      chk($sformatf("vec%0d_zero", i),  32'(out_zero),  32'(vecs[i].exp_zero));
      chk($sformatf("vec%0d_carry", i), 32'(out_carry), 32'(vecs[i].exp_carry));
      take();
    end

    // Back-pressure: result held for 10 cycles, no request accepted meanwhile.
    send(1'b1, 3'b011, 32'hFF, 32'h0F);
    wait_valid(lat);
    for (int c = 0; c < 10; c++) begin
      in0_valid = 1'b1; in0_op = 3'($urandom); in0_a = $urandom; in0_b = $urandom;
      in1_valid = 1'b1; in1_op = 3'($urandom); in1_a = $urandom; in1_b = $urandom;
      #1;
      chk($sformatf("hold%0d_data", c), out_data, 32'hF0);
      chk($sformatf("hold%0d_id", c), 32'(out_id), 32'd1);
      chk($sformatf("hold%0d_rdy", c), 32'({out_valid, in0_ready, in1_ready}), 32'b100);
      tick();
    end
    in0_op = 3'b100; in0_a = 32'd10;  in0_b = 32'd20;
    in1_op = 3'b101; in1_a = 32'd100; in1_b = 32'd1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_rdy", 32'({in0_ready, in1_ready}), 32'b10);
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    wait_valid(lat);
    chk("release_lat", 32'(lat), 32'd1);
    chk("release_data", out_data, 32'd30);
    chk("release_id", 32'(out_id), 32'd0);
    take();

    // Reset in the 3rd cycle of a 20-bit shift drops the request.
    send(1'b0, 3'b110, 32'h1, 32'd20);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    in0_valid = 1'b1; in1_valid = 1'b1;
    #1;
    chk("midrst_idle_rdy", 32'({in0_ready, in1_ready}), 32'b10);
    in0_valid = 1'b0; in1_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (out_valid === 1'b1) saw_valid = 1'b1;
    end
    chk("midrst_no_result", 32'(saw_valid), 32'd0);
    send(1'b1, 3'b000, 32'h0F0F_0F0F, 32'h0);
    wait_valid(lat);
    chk("post_rst_lat", 32'(lat), 32'd1);
    chk("post_rst_data", out_data, 32'hF0F0_F0F0);
    chk("post_rst_id", 32'(out_id), 32'd1);
    take();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
